jt900h_intc: RTL and testbench
==============================

JT900H_INTC -- requirements
Module: jt900h_intc

Interface
REQ-001 Parameter CH, default 8: number of interrupt channels, legal range 2..16.
REQ-002 Parameter VBASE, default 8'h20: vector address of channel 0.
REQ-003 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-low (asserted when 0).
REQ-005 Port cen  input  1: clock enable; all state changes only happen when cen=1, except reset.
REQ-006 Port req  input  CH: raw interrupt request per channel.
REQ-007 Port edge_mode  input  CH: 1 = channel latches rising edges; 0 = channel follows level.
REQ-008 Port prio  input  3*CH: 3-bit priority per channel, bits [3i+2:3i]; 0 = channel disabled.
REQ-009 Port riff  input  3: CPU interrupt mask level.
REQ-010 Port clr  input  CH: pending-clear per channel, edge mode only.
REQ-011 Port irq_ack  input  1: CPU acknowledge of the presented interrupt.
REQ-012 Port irq  output  1: interrupt request to CPU.
REQ-013 Port int_lvl  output  3: level of the presented interrupt.
REQ-014 Port int_addr  output  8: vector address of the presented interrupt.
REQ-015 Port pend  output  CH: pending flags.

Function
REQ-016 Pending, edge mode: the register sets on a cen cycle where req=1 and the previous sampled req=0; it clears on clr or on acknowledge of that channel; if set and clear fall in the same cycle, set wins.
REQ-017 Pending, level mode: the register loads req on every cen cycle; clr and acknowledge have no effect.
REQ-018 Eligible(i) is true when all of these hold: pend[i]=1; prio(i)!=0; and either prio(i)>riff or prio(i)=7. Level 7 is non-maskable.
REQ-019 Winner: the eligible channel with the highest prio; on a tie, the lowest index wins.
REQ-020 Vector: int_addr = VBASE + 4*index, truncated to 8 bits so that it wraps modulo 256.
REQ-021 The FSM has three states: IDLE, REQ and ACK.
REQ-022 IDLE, with any channel eligible: latch the winner index, int_lvl and int_addr; set irq=1; move to REQ.
REQ-023 REQ: int_lvl, int_addr and the latched index stay frozen, even if a higher-priority channel becomes eligible.
REQ-024 REQ with irq_ack=1: clear the latched channel's pending (edge mode only); set irq=0; move to ACK.
REQ-025 REQ with irq_ack=0 and the latched channel no longer eligible (clr, riff raised, level dropped, or prio changed): withdraw by setting irq=0 and moving to IDLE.
REQ-026 When irq_ack=1 and loss of eligibility happen in the same cycle, the acknowledge wins.
REQ-027 ACK: one-cycle gap with irq=0, then move to IDLE, where the next arbitration happens.
REQ-028 irq_ack is ignored in IDLE and in ACK.
REQ-029 Latency: a req edge sampled at cen cycle n gives pend=1 after n and irq=1 after cycle n+1.
REQ-030 Back-to-back interrupts from one edge channel: a new edge can occur at the earliest on the ack cycle; it is kept as pending and re-presented 2 cen cycles after ACK.
REQ-031 With cen=0, all registers and outputs hold their values and irq_ack is not sampled.
REQ-032 The block is fully synchronous; no combinational path runs from any input to irq, int_lvl or int_addr.

Reset
REQ-033 While rst=0, on every clk edge regardless of cen: state=IDLE; irq=0; int_lvl=0; int_addr=0; pend=0; latched index=0.
REQ-034 While rst=0, the sampled-req register loads req, so a request held high across reset does not create an edge.
REQ-035 A reset in REQ or ACK aborts the presentation; irq is 0 on the first cycle after reset is applied.

Verification
REQ-036 Edge channel 3, prio=5, riff=2, pulse req[3] for one cycle -> pend[3]=1 next cycle; irq=1 with int_lvl=5 and int_addr=8'h2C one cycle later; irq_ack -> pend[3]=0, irq=0.
REQ-037 Channels 1 and 6 both at prio=4, plus channel 2 at prio=6, raised together -> channel 2 served first (int_addr=8'h28), then channel 1 (8'h24), then channel 6 (8'h38).
REQ-038 riff=7, channel 0 at prio=6 and channel 5 at prio=7 both pending -> only channel 5 is presented (int_lvl=7); channel 0 stays pending and is never presented.
REQ-039 Channel 4 presented in REQ, then clr[4] pulsed before ack -> irq drops the next cycle, state returns to IDLE, no vector is taken.
REQ-040 Level-mode channel 7, prio=3, req held high, with cen toggling 1/0 -> irq rises only on cen cycles; ack then re-present after the ACK gap while req stays high; dropping req in REQ withdraws irq.
REQ-041 rst=0 asserted in REQ with req[2] held high -> the next cycle shows irq=0 and pend=0; after rst=1, no edge is detected on channel 2 (edge mode).

Source files
------------

// File: rtl/jt900h_intc.sv
`default_nettype none
// ============================================================================
//  Module   : jt900h_intc
//  Brief    : Prioritised interrupt controller with per-channel edge/level
//             pending, mask level, registered vector presentation and ack.
//  Revision : 1.0 - initial release
// ============================================================================
module jt900h_intc #(
  parameter int          CH    = 8,
  parameter logic [7:0]  VBASE = 8'h20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic [CH-1:0]   req,
  input  logic [CH-1:0]   edge_mode,
  input  logic [3*CH-1:0] prio,
  input  logic [2:0]      riff,
  input  logic [CH-1:0]   clr,
  input  logic            irq_ack,
  output logic            irq,
  output logic [2:0]      int_lvl,
  output logic [7:0]      int_addr,
  output logic [CH-1:0]   pend
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_req  = 2'd1;
  localparam logic [1:0] c_st_ack  = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [CH-1:0] r_req_d;
  logic [CH-1:0] r_pend;
  logic [CH-1:0] w_pend_nxt;
  logic [CH-1:0] w_elig;
  logic [3:0]    r_idx;
  logic [3:0]    w_idx_nxt;
  logic          r_irq;
  logic          w_irq_nxt;
  logic [2:0]    r_lvl;
  logic [2:0]    w_lvl_nxt;
  logic [7:0]    r_addr;
  logic [7:0]    w_addr_nxt;

  logic          w_win_valid;
  logic [3:0]    w_win_idx;
  logic [2:0]    w_win_lvl;
  logic [7:0]    w_win_addr;
  logic          w_cur_elig;
  logic          w_ack_take;

  // Acknowledge is only honoured while a vector is being presented
  assign w_ack_take = (r_state == c_st_req) && irq_ack;

  // --------------------------------------------------------------------------
  // Per-channel pending and eligibility
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic [2:0] w_p;
      logic       w_set;
      logic       w_clear;

      assign w_p     = prio[3*gi +: 3];
      assign w_set   = req[gi] & ~r_req_d[gi];
      assign w_clear = clr[gi] | (w_ack_take && (r_idx == 4'(gi)));

      // Edge channels: set beats clear in the same cycle
      assign w_pend_nxt[gi] = edge_mode[gi] ? (w_set | (r_pend[gi] & ~w_clear))
                                            : req[gi];

      assign w_elig[gi] = r_pend[gi] && (w_p != 3'd0) &&
                          ((w_p > riff) || (w_p == 3'd7));
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Winner: highest priority, lowest index on ties (strict compare)
  // --------------------------------------------------------------------------
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = 4'd0;
    w_win_lvl   = 3'd0;
    for (int i = 0; i < CH; i++) begin
      if (w_elig[i] && (prio[3*i +: 3] > w_win_lvl)) begin
        w_win_valid = 1'b1;
        w_win_idx   = 4'(i);
        w_win_lvl   = prio[3*i +: 3];
      end
    end
  end

  // Sum is 8 bits wide, so the vector wraps modulo 256
  assign w_win_addr = VBASE + {2'b00, w_win_idx, 2'b00};

  always_comb begin
    w_cur_elig = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (r_idx == 4'(i)) w_cur_elig = w_elig[i];
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= c_st_idle;
      r_irq   <= 1'b0;
      r_lvl   <= 3'd0;
      r_addr  <= 8'd0;
      r_idx   <= 4'd0;
    end else if (cen) begin
      r_state <= w_state_nxt;
      r_irq   <= w_irq_nxt;
      r_lvl   <= w_lvl_nxt;
      r_addr  <= w_addr_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_win_valid) w_state_nxt = c_st_req;
      c_st_req: begin
        if (w_ack_take)       w_state_nxt = c_st_ack;
        else if (!w_cur_elig) w_state_nxt = c_st_idle;
      end
      c_st_ack:  w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  // FSM: output logic (feeds registered outputs, so no input-to-output path)
  always_comb begin
    w_irq_nxt  = r_irq;
    w_lvl_nxt  = r_lvl;
    w_addr_nxt = r_addr;
    w_idx_nxt  = r_idx;
    case (r_state)
      c_st_idle: begin
        if (w_win_valid) begin
          w_irq_nxt  = 1'b1;
          w_lvl_nxt  = w_win_lvl;
          w_addr_nxt = w_win_addr;
          w_idx_nxt  = w_win_idx;
        end
      end
      c_st_req: begin
        if (w_ack_take || !w_cur_elig) w_irq_nxt = 1'b0;
      end
      default: w_irq_nxt = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request history and pending registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_req_d <= req;
      r_pend  <= '0;
    end else if (cen) begin
      r_req_d <= req;
      r_pend  <= w_pend_nxt;
    end
  end

  assign irq      = r_irq;
  assign int_lvl  = r_lvl;
  assign int_addr = r_addr;
  assign pend     = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_jt900h_intc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jt900h_intc
//  Brief    : Directed self-checking bench for jt900h_intc.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jt900h_intc;

  localparam int CH = 8;

  logic            clk;
  logic            rst;
  logic            cen;
  logic [CH-1:0]   req;
  logic [CH-1:0]   edge_mode;
  logic [3*CH-1:0] prio;
  logic [2:0]      riff;
  logic [CH-1:0]   clr;
  logic            irq_ack;
  logic            irq;
  logic [2:0]      int_lvl;
  logic [7:0]      int_addr;
  logic [CH-1:0]   pend;

  int n_checks = 0;
  int n_fail   = 0;

  jt900h_intc #(.CH(CH), .VBASE(8'h20)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .req       (req),
    .edge_mode (edge_mode),
    .prio      (prio),
    .riff      (riff),
    .clr       (clr),
    .irq_ack   (irq_ack),
    .irq       (irq),
    .int_lvl   (int_lvl),
    .int_addr  (int_addr),
    .pend      (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled and inputs changed 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_prio(input int ch, input logic [2:0] p);
    prio[3*ch +: 3] = p;
  endtask

  task automatic test_reset();
    rst = 1'b0; cen = 1'b1; req = '0; clr = '0; irq_ack = 1'b0;
    edge_mode = '1; prio = '0; riff = 3'd0;
    tick(); tick();
    n_checks++;
    if ({irq, int_lvl, int_addr, pend} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got irq=%0d lvl=%0d addr=%h pend=%h, want all zero",
               irq, int_lvl, int_addr, pend);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({irq, pend} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got irq=%0d pend=%h, want 0/00", irq, pend);
    end
  endtask

  task automatic test_edge_basic();
    prio = '0; set_prio(3, 3'd5); riff = 3'd2;
    req[3] = 1'b1;
    tick();
    req[3] = 1'b0;
    n_checks++;
    if ({pend, irq} !== {8'h08, 1'b0}) begin
      n_fail++;
      $display("FAIL edge_pend: got pend=%h irq=%0d, want 08/0", pend, irq);
    end
    tick();
    n_checks++;
    if ({irq, int_lvl, int_addr} !== {1'b1, 3'd5, 8'h2C}) begin
      n_fail++;
      $display("FAIL edge_present: got irq=%0d lvl=%0d addr=%h, want 1/5/2C", irq, int_lvl, int_addr);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    n_checks++;
    if ({irq, pend} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL edge_ack: got irq=%0d pend=%h, want 0/00", irq, pend);
    end
    tick(); tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_after_ack: got irq=%0d, want 0", irq);
    end
  endtask

  task automatic test_priority();
    logic [7:0] exp_addr [3];
    logic [2:0] exp_lvl  [3];
    exp_addr[0] = 8'h28; exp_lvl[0] = 3'd6;
    exp_addr[1] = 8'h24; exp_lvl[1] = 3'd4;
    exp_addr[2] = 8'h38; exp_lvl[2] = 3'd4;
    prio = '0; set_prio(1, 3'd4); set_prio(6, 3'd4); set_prio(2, 3'd6); riff = 3'd2;
    req = 8'h46;
    tick();
    req = '0;
    n_checks++;
    if (pend !== 8'h46) begin
      n_fail++;
      $display("FAIL prio_pend: got pend=%h, want 46", pend);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({irq, int_lvl, int_addr} !== {1'b1, exp_lvl[k], exp_addr[k]}) begin
        n_fail++;
        $display("FAIL prio_order_%0d: got irq=%0d lvl=%0d addr=%h, want 1/%0d/%h",
                 k, irq, int_lvl, int_addr, exp_lvl[k], exp_addr[k]);
      end
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      tick();
      tick();
    end
    n_checks++;
    if ({irq, pend} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL prio_drained: got irq=%0d pend=%h, want 0/00", irq, pend);
    end
  endtask

  task automatic test_mask();
    prio = '0; set_prio(0, 3'd6); set_prio(5, 3'd7); riff = 3'd7;
    req = 8'h21;
    tick();
    req = '0;
    tick();
    n_checks++;
    if ({irq, int_lvl, int_addr} !== {1'b1, 3'd7, 8'h34}) begin
      n_fail++;
      $display("FAIL mask_nmi: got irq=%0d lvl=%0d addr=%h, want 1/7/34", irq, int_lvl, int_addr);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tick(); tick(); tick(); tick();
    n_checks++;
    if ({irq, pend} !== {1'b0, 8'h01}) begin
      n_fail++;
      $display("FAIL mask_blocked: got irq=%0d pend=%h, want 0/01", irq, pend);
    end
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    n_checks++;
    if (pend !== 8'h00) begin
      n_fail++;
      $display("FAIL mask_clr: got pend=%h, want 00", pend);
    end
  endtask

  task automatic test_withdraw();
    prio = '0; set_prio(4, 3'd2); riff = 3'd0;
    req[4] = 1'b1;
    tick();
    req[4] = 1'b0;
    tick();
    n_checks++;
    if ({irq, int_lvl, int_addr} !== {1'b1, 3'd2, 8'h30}) begin
      n_fail++;
      $display("FAIL wd_present: got irq=%0d lvl=%0d addr=%h, want 1/2/30", irq, int_lvl, int_addr);
    end
    clr[4] = 1'b1;
    tick();
    clr[4] = 1'b0;
    n_checks++;
    if (pend !== 8'h00) begin
      n_fail++;
      $display("FAIL wd_clr: got pend=%h, want 00", pend);
    end
    tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_drop: got irq=%0d, want 0", irq);
    end
    tick(); tick();
    n_checks++;
    if ({irq, pend} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL wd_idle: got irq=%0d pend=%h, want 0/00", irq, pend);
    end
  endtask

  task automatic test_back_to_back();
    prio = '0; set_prio(3, 3'd5); riff = 3'd2;
    req[3] = 1'b1;
    tick();
    req[3] = 1'b0;
    tick();
    irq_ack = 1'b1; req[3] = 1'b1;
    tick();
    irq_ack = 1'b0; req[3] = 1'b0;
    n_checks++;
    if ({irq, pend} !== {1'b0, 8'h08}) begin
      n_fail++;
      $display("FAIL b2b_keep: got irq=%0d pend=%h, want 0/08", irq, pend);
    end
    tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: got irq=%0d, want 0", irq);
    end
    tick();
    n_checks++;
    if ({irq, int_addr} !== {1'b1, 8'h2C}) begin
      n_fail++;
      $display("FAIL b2b_represent: got irq=%0d addr=%h, want 1/2C", irq, int_addr);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tick(); tick();
    n_checks++;
    if ({irq, pend} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL b2b_done: got irq=%0d pend=%h, want 0/00", irq, pend);
    end
  endtask

  task automatic test_level_cen();
    edge_mode = 8'h7F; prio = '0; set_prio(7, 3'd3); riff = 3'd0;
    req[7] = 1'b1; cen = 1'b1;
    tick();
    cen = 1'b0;
    tick();
    n_checks++;
    if ({irq, pend} !== {1'b0, 8'h80}) begin
      n_fail++;
      $display("FAIL lvl_hold: got irq=%0d pend=%h, want 0/80", irq, pend);
    end
    cen = 1'b1;
    tick();
    n_checks++;
    if ({irq, int_lvl, int_addr} !== {1'b1, 3'd3, 8'h3C}) begin
      n_fail++;
      $display("FAIL lvl_present: got irq=%0d lvl=%0d addr=%h, want 1/3/3C", irq, int_lvl, int_addr);
    end
    cen = 1'b0; irq_ack = 1'b1;
    tick();
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL lvl_ack_gated: got irq=%0d, want 1", irq);
    end
    cen = 1'b1;
    tick();
    irq_ack = 1'b0;
    n_checks++;
    if ({irq, pend} !== {1'b0, 8'h80}) begin
      n_fail++;
      $display("FAIL lvl_ack: got irq=%0d pend=%h, want 0/80", irq, pend);
    end
    cen = 1'b0; tick();
    cen = 1'b1; tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL lvl_gap: got irq=%0d, want 0", irq);
    end
    cen = 1'b0; tick();
    cen = 1'b1; tick();
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL lvl_represent: got irq=%0d, want 1", irq);
    end
    req[7] = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({irq, pend} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL lvl_withdraw: got irq=%0d pend=%h, want 0/00", irq, pend);
    end
    edge_mode = '1;
    tick();
  endtask

  task automatic test_reset_in_req();
    prio = '0; set_prio(2, 3'd4); riff = 3'd0;
    req[2] = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({irq, int_addr} !== {1'b1, 8'h28}) begin
      n_fail++;
      $display("FAIL rstreq_present: got irq=%0d addr=%h, want 1/28", irq, int_addr);
    end
    rst = 1'b0; cen = 1'b0;
    tick();
    n_checks++;
    if ({irq, int_lvl, int_addr, pend} !== '0) begin
      n_fail++;
      $display("FAIL rstreq_abort: got irq=%0d lvl=%0d addr=%h pend=%h, want zeros",
               irq, int_lvl, int_addr, pend);
    end
    rst = 1'b1; cen = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if ({irq, pend} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL rstreq_no_edge: got irq=%0d pend=%h, want 0/00", irq, pend);
    end
    req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_edge_basic();
    test_priority();
    test_mask();
    test_withdraw();
    test_back_to_back();
    test_level_cen();
    test_reset_in_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
